// File: rtl/melody_player.sv
// melody_player: programmable note/rest sequencer driving a square-wave buzzer output.
// Build option MELODY_PLAYER_NOTE_GAP_EN silences the final step of every note.

module melody_player_entry #(
  parameter logic [5:0] INIT = 6'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [5:0] wr_data,
  output logic [5:0] q
);
  always_ff @(posedge clk) begin
    if (!rst_n)     q <= INIT;
    else if (wr_en) q <= wr_data;
  end
endmodule

module melody_player #(
  parameter int CLOCK_FREQ     = 1000000,
  parameter int TICK_DIV       = 5000,
  parameter int STEP_TICKS     = 25,
  parameter int STEPS_PER_NOTE = 4,
  parameter int SEQ_LEN        = 8,
  parameter int ADDR_BITS      = 3,
  parameter int COUNTER_BITS   = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 loop,
  input  logic                 seq_wr_en,
  input  logic [ADDR_BITS-1:0] seq_wr_addr,
  input  logic [5:0]           seq_wr_data,
  output logic                 busy,
  output logic [ADDR_BITS-1:0] note_idx,
  output logic                 done,
  output logic                 buzzer_out
);
  localparam int TW = (TICK_DIV > 1)       ? $clog2(TICK_DIV)       : 1;
  localparam int SW = (STEP_TICKS > 1)     ? $clog2(STEP_TICKS)     : 1;
  localparam int NW = (STEPS_PER_NOTE > 1) ? $clog2(STEPS_PER_NOTE) : 1;
  localparam logic [TW-1:0]        TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0]        STEP_LAST = SW'(STEP_TICKS - 1);
  localparam logic [NW-1:0]        SIDX_LAST = NW'(STEPS_PER_NOTE - 1);
  localparam logic [ADDR_BITS-1:0] IDX_LAST  = ADDR_BITS'(SEQ_LEN - 1);

  typedef struct packed {
    logic       rest;
    logic [4:0] id;
  } note_t;

  typedef enum logic {IDLE, PLAY} state_t;

  if (SEQ_LEN < 2 || ADDR_BITS != $clog2(SEQ_LEN) || COUNTER_BITS < 10 || CLOCK_FREQ < 1)
  begin : g_cfg_err
    $error("melody_player: inconsistent parameters");
  end

  function automatic logic [5:0] default_entry(input int i);
    case (i)
      0:       default_entry = 6'd21;
      1:       default_entry = 6'd16;
      2:       default_entry = 6'd14;
      3:       default_entry = 6'd12;
      4:       default_entry = 6'd9;
      5:       default_entry = 6'd12;
      6:       default_entry = 6'd14;
      7:       default_entry = 6'd16;
      default: default_entry = 6'h20;
    endcase
  endfunction

  // Half-period count max at 1 MHz, C5..B6.
  function automatic logic [9:0] note_max(input logic [4:0] id);
    case (id)
      5'd0:    note_max = 10'd956;
      5'd1:    note_max = 10'd902;
      5'd2:    note_max = 10'd851;
      5'd3:    note_max = 10'd804;
      5'd4:    note_max = 10'd758;
      5'd5:    note_max = 10'd716;
      5'd6:    note_max = 10'd676;
      5'd7:    note_max = 10'd638;
      5'd8:    note_max = 10'd602;
      5'd9:    note_max = 10'd568;
      5'd10:   note_max = 10'd536;
      5'd11:   note_max = 10'd506;
      5'd12:   note_max = 10'd478;
      5'd13:   note_max = 10'd451;
      5'd14:   note_max = 10'd426;
      5'd15:   note_max = 10'd402;
      5'd16:   note_max = 10'd379;
      5'd17:   note_max = 10'd358;
      5'd18:   note_max = 10'd338;
      5'd19:   note_max = 10'd319;
      5'd20:   note_max = 10'd301;
      5'd21:   note_max = 10'd284;
      5'd22:   note_max = 10'd268;
      5'd23:   note_max = 10'd253;
      default: note_max = 10'd0;
    endcase
  endfunction

  logic [SEQ_LEN-1:0][5:0] seq_q;

  // Addresses at or above SEQ_LEN decode to no entry, so such writes drop.
  for (genvar i = 0; i < SEQ_LEN; i++) begin : g_seq
    melody_player_entry #(.INIT(default_entry(i))) u_entry (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (seq_wr_en && (seq_wr_addr == ADDR_BITS'(i))),
      .wr_data (seq_wr_data),
      .q       (seq_q[i])
    );
  end

  state_t                  state_q, state_d;
  logic [TW-1:0]           tick_q, tick_d, tick_adv;
  logic [SW-1:0]           step_q, step_d, step_adv;
  logic [NW-1:0]           sidx_q, sidx_d, sidx_adv;
  logic [ADDR_BITS-1:0]    idx_q, idx_d, next_idx;
  note_t                   cur_q, cur_d;
  logic [COUNTER_BITS-1:0] freq_q, freq_d, cur_max;
  logic                    buz_q, buz_d, done_q, done_d;
  logic                    tick_end, step_end, note_end, last_entry, silent;

  always_comb begin
    tick_end   = (tick_q == TICK_LAST);
    step_end   = tick_end && (step_q == STEP_LAST);
    note_end   = step_end && (sidx_q == SIDX_LAST);
    last_entry = (idx_q == IDX_LAST);
    tick_adv   = tick_end ? '0 : tick_q + 1'b1;
    step_adv   = !tick_end ? step_q : (step_end ? '0 : step_q + 1'b1);
    sidx_adv   = !step_end ? sidx_q : (note_end ? '0 : sidx_q + 1'b1);
    next_idx   = last_entry ? '0 : idx_q + 1'b1;
    cur_max    = COUNTER_BITS'(note_max(cur_q.id));
`ifdef MELODY_PLAYER_NOTE_GAP_EN
    // Registered output, so silence is keyed on the step being entered.
    silent     = cur_q.rest || (cur_q.id >= 5'd24) || (sidx_adv == SIDX_LAST);
`else
    silent     = cur_q.rest || (cur_q.id >= 5'd24);
`endif
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    step_d  = step_q;
    sidx_d  = sidx_q;
    idx_d   = idx_q;
    cur_d   = cur_q;
    freq_d  = freq_q;
    buz_d   = buz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tick_d = '0;
        step_d = '0;
        sidx_d = '0;
        idx_d  = '0;
        freq_d = '0;
        buz_d  = 1'b1;
        if (start && !stop) begin
          state_d = PLAY;
          cur_d   = seq_q[0];
        end
      end
      PLAY: begin
        if (stop || (note_end && last_entry && !loop)) begin
          state_d = IDLE;
          done_d  = !stop;
          tick_d  = '0;
          step_d  = '0;
          sidx_d  = '0;
          idx_d   = '0;
          freq_d  = '0;
          buz_d   = 1'b1;
        end else if (note_end) begin
          // Latch the next entry and restart the tone phase.
          tick_d = '0;
          step_d = '0;
          sidx_d = '0;
          idx_d  = next_idx;
          cur_d  = seq_q[next_idx];
          freq_d = '0;
          buz_d  = 1'b1;
        end else begin
          tick_d = tick_adv;
          step_d = step_adv;
          sidx_d = sidx_adv;
          if (silent) begin
            freq_d = '0;
            buz_d  = 1'b1;
          end else if (freq_q == cur_max) begin
            freq_d = '0;
            buz_d  = ~buz_q;
          end else begin
            freq_d = freq_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      step_q  <= '0;
      sidx_q  <= '0;
      idx_q   <= '0;
      cur_q   <= '0;
      freq_q  <= '0;
      buz_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      step_q  <= step_d;
      sidx_q  <= sidx_d;
      idx_q   <= idx_d;
      cur_q   <= cur_d;
      freq_q  <= freq_d;
      buz_q   <= buz_d;
      done_q  <= done_d;
    end
  end

  assign busy       = (state_q == PLAY);
  assign note_idx   = idx_q;
  assign done       = done_q;
  assign buzzer_out = buz_q;

endmodule

// File: tb/tb_melody_player.sv
// tb_melody_player: directed + random stimulus vs an elapsed-time reference model.
// Two DUTs share inputs: SEQ_LEN=8 and SEQ_LEN=6 (exercises out-of-range writes).
module tb_melody_player;
  localparam int TD = 100, ST = 5, SPN = 4, N = TD * ST * SPN;
  localparam int NOTE_MAX [24] = '{956, 902, 851, 804, 758, 716, 676, 638, 602, 568, 536, 506,
                                   478, 451, 426, 402, 379, 358, 338, 319, 301, 284, 268, 253};
  localparam logic [5:0] DEF [8] = '{6'd21, 6'd16, 6'd14, 6'd12, 6'd9, 6'd12, 6'd14, 6'd16};

  logic       clk = 1'b0;
  logic       rst_n, start, stop, loop, seq_wr_en;
  logic [2:0] seq_wr_addr;
  logic [5:0] seq_wr_data;
  logic       busy8, done8, buz8, busy6, done6, buz6;
  logic [2:0] idx8, idx6;

  always #5 clk = ~clk;

  melody_player #(.TICK_DIV(TD), .STEP_TICKS(ST), .STEPS_PER_NOTE(SPN)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
    .seq_wr_en(seq_wr_en), .seq_wr_addr(seq_wr_addr), .seq_wr_data(seq_wr_data),
    .busy(busy8), .note_idx(idx8), .done(done8), .buzzer_out(buz8)
  );

  melody_player #(.TICK_DIV(TD), .STEP_TICKS(ST), .STEPS_PER_NOTE(SPN),
                  .SEQ_LEN(6), .ADDR_BITS(3)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
    .seq_wr_en(seq_wr_en), .seq_wr_addr(seq_wr_addr), .seq_wr_data(seq_wr_data),
    .busy(busy6), .note_idx(idx6), .done(done6), .buzzer_out(buz6)
  );

  // Model: playing flag, cycles since playback start, latched entry, tune table.
  bit         m_play [2];
  bit         m_done [2];
  int         m_t    [2];
  logic [5:0] m_cur  [2];
  logic [5:0] m_tune [2][8];
  int         n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      if (n_fail >= 20) begin
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    end
  endtask

  function automatic logic exp_buz(input logic [5:0] e, input int r);
    int hp;
    if (e[5] || e[4:0] >= 5'd24) return 1'b1;
`ifdef MELODY_PLAYER_NOTE_GAP_EN
    if ((r / (TD * ST)) == SPN - 1) return 1'b1;
`endif
    hp = NOTE_MAX[int'(e[4:0])] + 1;
    return ((r / hp) % 2) == 0;
  endfunction

  function automatic logic [5:0] exp_outs(input int u, input int slen);
    logic [2:0] idx;
    logic       bz;
    idx = m_play[u] ? 3'((m_t[u] / N) % slen) : 3'd0;
    bz  = m_play[u] ? exp_buz(m_cur[u], m_t[u] % N) : 1'b1;
    return {m_play[u], idx, m_done[u], bz};
  endfunction

  task automatic model_edge(input int u, input int slen);
    int t1, k;
    if (!rst_n) begin
      m_play[u] = 1'b0;
      m_done[u] = 1'b0;
      for (int i = 0; i < 8; i++) m_tune[u][i] = (i < slen) ? DEF[i] : 6'h20;
    end else begin
      m_done[u] = 1'b0;
      if (!m_play[u]) begin
        if (start && !stop) begin
          m_play[u] = 1'b1;
          m_t[u]    = 0;
          m_cur[u]  = m_tune[u][0];
        end
      end else if (stop) begin
        m_play[u] = 1'b0;
      end else begin
        t1 = m_t[u] + 1;
        if (t1 % N == 0) begin
          k = (t1 / N) % slen;
          if (k == 0 && !loop) begin
            m_play[u] = 1'b0;
            m_done[u] = 1'b1;
          end else begin
            m_t[u]   = t1;
            m_cur[u] = m_tune[u][k];
          end
        end else begin
          m_t[u] = t1;
        end
      end
      if (seq_wr_en && int'(seq_wr_addr) < slen) m_tune[u][seq_wr_addr] = seq_wr_data;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0, 8);
    model_edge(1, 6);
    @(negedge clk);
    chk("outs8", {26'd0, busy8, idx8, done8, buz8}, {26'd0, exp_outs(0, 8)});
    chk("outs6", {26'd0, busy6, idx6, done6, buz6}, {26'd0, exp_outs(1, 6)});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int zeros;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
    seq_wr_en = 1'b0; seq_wr_addr = '0; seq_wr_data = '0;
    run(2);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_buz", buz8, 1'b1);
    rst_n = 1'b1;
    run(3);

    // Default tune, one-shot: first note edges, note 1 period, done at 16000.
    kick();
    chk("start_busy", busy8, 1'b1);
    run(284);  chk("c284_buz", buz8, 1'b1);
    run(1);    chk("c285_buz", buz8, 1'b0);
    run(285);  chk("c570_buz", buz8, 1'b1);
    run(1430); chk("c2000_idx", idx8, 3'd1);
    run(379);  chk("c2379_buz", buz8, 1'b1);
    run(1);    chk("c2380_buz", buz8, 1'b0);
    run(13620);
    chk("c16000_done", done8, 1'b1);
    chk("c16000_busy", busy8, 1'b0);
    chk("c16000_buz", buz8, 1'b1);
    run(1);    chk("done_pulse", done8, 1'b0);
    run(10);

    // Replay with loop, then drop loop mid-sequence.
    loop = 1'b1;
    kick();
    chk("replay_idx", idx8, 3'd0);
    run(16000);
    chk("wrap_done", done8, 1'b0);
    chk("wrap_idx", idx8, 3'd0);
    chk("wrap_busy", busy8, 1'b1);
    run(285);  chk("wrap_buz", buz8, 1'b0);
    run(715);  loop = 1'b0;
    run(15000);
    chk("loop_end_done", done8, 1'b1);
    run(1);

    // Rewrite entry 2 as a rest while entry 1 plays; addr 7 is out of range for u_dut6.
    kick();
    run(2500);
    seq_wr_en = 1'b1; seq_wr_addr = 3'd2; seq_wr_data = 6'h20;
    step();
    seq_wr_addr = 3'd7; seq_wr_data = 6'h00;
    step();
    seq_wr_en = 1'b0;
    run(1498);
    zeros = 0;
    for (int i = 0; i < 2000; i++) begin
      if (buz8 !== 1'b1) zeros++;
      step();
    end
    chk("rest_hold", zeros, 0);
    chk("after_rest_idx", idx8, 3'd3);
    stop = 1'b1; step(); stop = 1'b0;

    // stop+start together, then reset mid-note restores the default tune.
    kick();
    run(3000);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("stop_busy", busy8, 1'b0);
    chk("stop_done", done8, 1'b0);
    chk("stop_buz", buz8, 1'b1);
    kick();
    run(1000);
    rst_n = 1'b0;
    step();
    chk("midrst_outs", {busy8, idx8, done8, buz8}, 6'b0_000_0_1);
    seq_wr_en = 1'b1; seq_wr_addr = 3'd0; seq_wr_data = 6'h20;
    step();
    seq_wr_en = 1'b0; rst_n = 1'b1;
    kick();
    run(285);  chk("rst_e0_buz", buz8, 1'b0);
    run(3715); chk("rst_e2_idx", idx8, 3'd2);
    run(427);  chk("rst_e2_buz", buz8, 1'b0);
    stop = 1'b1; step(); stop = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      start = ($urandom_range(0, 299) == 0);
      stop  = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 999) == 0) loop = ~loop;
      rst_n       = ($urandom_range(0, 7999) != 0);
      seq_wr_en   = ($urandom_range(0, 199) == 0);
      seq_wr_addr = 3'($urandom_range(0, 7));
      seq_wr_data = 6'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
